// File: rtl/hyperbus_ck_en_gen_if.sv
// HyperBus CK enable generator: request/control/status bundle.
// Master drives requests and data-phase controls; slave returns CK/CS state.
interface hyperbus_ck_en_gen_if #(
    parameter int LenWidth = 16
);
    logic                trans_valid_i;
    logic                trans_ready_o;
    logic [3:0]          latency_i;
    logic [LenWidth-1:0] burst_len_i;
    logic                dbl_lat_i;
    logic                hold_i;
    logic                abort_i;
    logic                ck_en_o;
    logic                cs_no;
    logic                ca_phase_o;
    logic                data_phase_o;
    logic                done_o;

    modport master (
        output trans_valid_i, latency_i, burst_len_i,
        output dbl_lat_i, hold_i, abort_i,
        input  trans_ready_o, ck_en_o, cs_no,
        input  ca_phase_o, data_phase_o, done_o
    );

    modport slave (
        input  trans_valid_i, latency_i, burst_len_i,
        input  dbl_lat_i, hold_i, abort_i,
        output trans_ready_o, ck_en_o, cs_no,
        output ca_phase_o, data_phase_o, done_o
    );
endinterface

// File: rtl/hyperbus_ck_en_gen.sv
// HyperBus CK enable / chip-select sequencer: CA, latency, data, tail, CS-high.
// Define HYPERBUS_CK_EN_GEN_FIXED_LAT_EN to always use doubled latency.
module hyperbus_ck_en_gen #(
    parameter int LenWidth     = 16,
    parameter int CsHighCycles = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    hyperbus_ck_en_gen_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        DATA,
        TAIL,
        CSHI
    } state_e;

    localparam logic [3:0]          CsLast = 4'(CsHighCycles - 1);
    localparam logic [LenWidth-1:0] LenOne = LenWidth'(1);

    state_e              state_q;
    state_e              state_d;
    logic [1:0]          ca_cnt_q;
    logic [4:0]          lat_cnt_q;
    logic [LenWidth-1:0] data_cnt_q;
    logic [LenWidth-1:0] len_q;
    logic [3:0]          lat_q;
    logic [3:0]          cs_cnt_q;
    logic                ck_phase_q;
    logic [4:0]          lat_eff;
    logic                accept;

    assign accept = bus.trans_valid_i && (state_q == IDLE);

    // Effective latency length, resolved in the last CA cycle.
    always_comb begin
        lat_eff = {1'b0, lat_q};
`ifdef HYPERBUS_CK_EN_GEN_FIXED_LAT_EN
        lat_eff = {lat_q, 1'b0};
`else
        if (bus.dbl_lat_i) begin
            lat_eff = {lat_q, 1'b0};
        end
`endif
    end

    // Next-state logic; abort wins over hold and phase advance.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.trans_valid_i) state_d = CA;
            end
            CA: begin
                if (bus.abort_i) begin
                    state_d = TAIL;
                end else if (ca_cnt_q == 2'd2) begin
                    if (lat_eff != 5'd0)   state_d = LAT;
                    else if (len_q != '0)  state_d = DATA;
                    else                   state_d = TAIL;
                end
            end
            LAT: begin
                if (bus.abort_i) begin
                    state_d = TAIL;
                end else if (lat_cnt_q == 5'd1) begin
                    state_d = (len_q != '0) ? DATA : TAIL;
                end
            end
            DATA: begin
                if (bus.abort_i) begin
                    state_d = TAIL;
                end else if (!bus.hold_i && data_cnt_q == LenOne) begin
                    state_d = TAIL;
                end
            end
            TAIL: state_d = CSHI;
            CSHI: begin
                if (cs_cnt_q == CsLast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, phase counters and captured request fields.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ck_phase_q <= 1'b0;
            ca_cnt_q   <= '0;
            lat_cnt_q  <= '0;
            data_cnt_q <= '0;
            cs_cnt_q   <= '0;
            lat_q      <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            ck_phase_q <= (state_d == CA) || (state_d == LAT)
                          || (state_d == DATA);
            if (accept) begin
                lat_q <= bus.latency_i;
                len_q <= bus.burst_len_i;
            end
            ca_cnt_q <= (state_q == CA) ? ca_cnt_q + 2'd1 : 2'd0;
            if (state_d != LAT) begin
                lat_cnt_q <= '0;
            end else if (state_q != LAT) begin
                lat_cnt_q <= lat_eff;
            end else begin
                lat_cnt_q <= lat_cnt_q - 5'd1;
            end
            if (state_d != DATA) begin
                data_cnt_q <= '0;
            end else if (state_q != DATA) begin
                data_cnt_q <= len_q;
            end else if (!bus.hold_i) begin
                data_cnt_q <= data_cnt_q - LenOne;
            end
            cs_cnt_q <= (state_q == CSHI) ? cs_cnt_q + 4'd1 : 4'd0;
        end
    end

    assign bus.trans_ready_o = (state_q == IDLE);
    assign bus.cs_no         = (state_q == IDLE) || (state_q == CSHI);
    assign bus.ca_phase_o    = (state_q == CA);
    assign bus.data_phase_o  = (state_q == DATA);
    assign bus.done_o        = (state_q == CSHI) && (cs_cnt_q == 4'd0);
    assign bus.ck_en_o       = ck_phase_q
                               && !(bus.hold_i && state_q == DATA);

endmodule

// File: tb/tb_hyperbus_ck_en_gen.sv
// Bench for hyperbus_ck_en_gen: per-transaction cycle counts via scoreboard,
// plus back-to-back, abort-with-hold and asynchronous reset sequences.
module tb_hyperbus_ck_en_gen;

    localparam int LW = 16;

    logic clk_i = 1'b0;
    logic rst_i;

    hyperbus_ck_en_gen_if #(.LenWidth(LW)) bus ();

    hyperbus_ck_en_gen #(
        .LenWidth    (LW),
        .CsHighCycles(2)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int lat; int len; int dbl;
        int hf;  int ht;  int ab;
        int ck;  int ca;  int dp; int dpe; int cslow;
    } vec_t;

    typedef struct {
        int ck; int ca; int dp; int dpe; int cslow;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    int nvec = 0;
    int nerr = 0;
    int hf = 0;
    int ht = 0;
    int ab = 0;
    int done_total = 0;

    int m_ck, m_ca, m_dp, m_dpe, m_cslow, m_cshi;
    logic rdy_prev;

    task automatic check(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: accumulate per-transaction cycle counts, compare on done_o.
    initial begin
        exp_t e;
        m_ck = 0; m_ca = 0; m_dp = 0; m_dpe = 0; m_cslow = 0; m_cshi = 0;
        rdy_prev = 1'b1;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                m_ck = 0; m_ca = 0; m_dp = 0; m_dpe = 0;
                m_cslow = 0; m_cshi = 0;
                rdy_prev = 1'b1;
            end else begin
                if (!bus.cs_no)                       m_cslow++;
                if (bus.ck_en_o)                      m_ck++;
                if (bus.ca_phase_o)                   m_ca++;
                if (bus.data_phase_o)                 m_dp++;
                if (bus.data_phase_o && bus.ck_en_o)  m_dpe++;
                if (bus.cs_no && !bus.trans_ready_o)  m_cshi++;
                if (bus.done_o) begin
                    done_total++;
                    check("done_ready", int'(bus.trans_ready_o), 0);
                    check("sb_nonempty", int'(sb.size() > 0), 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("ck_en_cycles", m_ck, e.ck);
                        check("ca_cycles", m_ca, e.ca);
                        check("data_cycles", m_dp, e.dp);
                        check("data_en_cycles", m_dpe, e.dpe);
                        check("cs_low_cycles", m_cslow, e.cslow);
                    end
                    m_ck = 0; m_ca = 0; m_dp = 0; m_dpe = 0; m_cslow = 0;
                end
                if (bus.trans_ready_o && !rdy_prev) begin
                    check("cs_high_cycles", m_cshi, 2);
                    m_cshi = 0;
                end
                rdy_prev = bus.trans_ready_o;
            end
        end
    end

    // Hold/abort driver keyed to the DATA cycle index (1-based).
    initial begin
        int dcyc;
        dcyc = 0;
        bus.hold_i  = 1'b0;
        bus.abort_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (bus.data_phase_o) dcyc++;
            else                  dcyc = 0;
            bus.hold_i  = bus.data_phase_o && hf != 0
                          && dcyc >= hf && dcyc <= ht;
            bus.abort_i = bus.data_phase_o && ab != 0 && dcyc == ab;
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.trans_ready_o && n < 200) begin
            @(posedge clk_i); #1; n++;
        end
        if (n >= 200) check("ready_timeout", int'(bus.trans_ready_o), 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done_o && n < 300) begin
            @(posedge clk_i); #1; n++;
        end
        if (n >= 300) check("done_timeout", int'(bus.done_o), 1);
    endtask

    task automatic send(input vec_t v);
        exp_t e;
        e = '{v.ck, v.ca, v.dp, v.dpe, v.cslow};
        hf = v.hf; ht = v.ht; ab = v.ab;
        bus.latency_i   = 4'(v.lat);
        bus.burst_len_i = LW'(v.len);
        bus.dbl_lat_i   = v.dbl[0];
        wait_ready();
        bus.trans_valid_i = 1'b1;
        @(posedge clk_i);
        sb.push_back(e);
        #1;
        bus.trans_valid_i = 1'b0;
        wait_done();
    endtask

    initial begin
        int n;
        int dsnap;
        exp_t e0;

        //          lat len dbl hf ht ab  ck ca dp dpe cslow
        vecs[0] = '{6,  4,  0,  0, 0, 0,  13, 3, 4, 4,  14};
        vecs[1] = '{6,  4,  1,  0, 0, 0,  19, 3, 4, 4,  20};
        vecs[2] = '{0,  0,  0,  0, 0, 0,  3,  3, 0, 0,  4};
        vecs[3] = '{0,  5,  1,  0, 0, 0,  8,  3, 5, 5,  9};
        vecs[4] = '{3,  8,  0,  3, 5, 0,  14, 3, 11, 8, 18};
        vecs[5] = '{2,  6,  0,  2, 2, 2,  6,  3, 2, 1,  8};
        vecs[6] = '{15, 1,  1,  0, 0, 0,  34, 3, 1, 1,  35};
        vecs[7] = '{1,  2,  0,  0, 0, 0,  6,  3, 2, 2,  7};
`ifdef HYPERBUS_CK_EN_GEN_FIXED_LAT_EN
        vecs[0].ck = 19; vecs[0].cslow = 20;
        vecs[4].ck = 17; vecs[4].cslow = 21;
        vecs[5].ck = 8;  vecs[5].cslow = 10;
        vecs[7].ck = 7;  vecs[7].cslow = 8;
`endif

        rst_i             = 1'b1;
        bus.trans_valid_i = 1'b0;
        bus.latency_i     = '0;
        bus.burst_len_i   = '0;
        bus.dbl_lat_i     = 1'b0;

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ck_en", int'(bus.ck_en_o), 0);
        check("rst_cs_n", int'(bus.cs_no), 1);
        check("rst_ca_phase", int'(bus.ca_phase_o), 0);
        check("rst_data_phase", int'(bus.data_phase_o), 0);
        check("rst_done", int'(bus.done_o), 0);
        check("rst_ready", int'(bus.trans_ready_o), 1);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
        end

        // Back-to-back: valid held high; next accept only after CS-high.
        hf = 0; ht = 0; ab = 0;
        e0 = '{3, 3, 0, 0, 4};
        bus.latency_i   = 4'd0;
        bus.burst_len_i = '0;
        bus.dbl_lat_i   = 1'b0;
        wait_ready();
        bus.trans_valid_i = 1'b1;
        @(posedge clk_i);
        sb.push_back(e0);
        #1;
        wait_done();
        n = 0;
        while (!bus.ca_phase_o && n < 20) begin
            @(posedge clk_i); #1; n++;
        end
        check("b2b_gap", n, 3);
        sb.push_back(e0);
        bus.trans_valid_i = 1'b0;
        wait_done();

        // Reset during LAT: CK off and CS high without a clock edge, no done.
        wait_ready();
        bus.latency_i   = 4'd6;
        bus.burst_len_i = LW'(4);
        bus.dbl_lat_i   = 1'b0;
        bus.trans_valid_i = 1'b1;
        @(posedge clk_i); #1;
        bus.trans_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #2;
        check("pre_rst_ck_en", int'(bus.ck_en_o), 1);
        check("pre_rst_cs_n", int'(bus.cs_no), 0);
        dsnap = done_total;
        rst_i = 1'b1;
        #1;
        check("async_rst_ck_en", int'(bus.ck_en_o), 0);
        check("async_rst_cs_n", int'(bus.cs_no), 1);
        check("async_rst_done", int'(bus.done_o), 0);
        check("async_rst_ready", int'(bus.trans_ready_o), 1);
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        check("rst_no_done", done_total, dsnap);
        check("rst_idle_cs_n", int'(bus.cs_no), 1);
        check("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/hyperbus_ck_en_gen.md
HYPERBUS_CK_EN_GEN -- requirements
Module: hyperbus_ck_en_gen

Interface
REQ-001 SHALL have parameter LenWidth, default 16, width of burst length in CK cycles.
REQ-002 SHALL have parameter CsHighCycles, default 2, minimum cs_no-high cycles between transactions (legal range 1..15).
REQ-003 SHALL have port clk_i  input  1  system clock; one CK period per clk_i cycle.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port trans_valid_i  input  1  transaction request.
REQ-006 SHALL have port trans_ready_o  output  1  request accepted when valid and ready are both high.
REQ-007 SHALL have port latency_i  input  4  initial latency in CK cycles; 0 means no latency phase.
REQ-008 SHALL have port burst_len_i  input  LenWidth  data phase length in CK cycles; 0 means no data phase.
REQ-009 SHALL have port dbl_lat_i  input  1  device requests doubled latency (RWDS high during command/address phase).
REQ-010 SHALL have port hold_i  input  1  data not ready; stalls CK during the data phase.
REQ-011 SHALL have port abort_i  input  1  terminate the current transaction.
REQ-012 SHALL have port ck_en_o  output  1  enable driven into the gated differential clock output stage.
REQ-013 SHALL have port cs_no  output  1  chip select, active-low.
REQ-014 SHALL have port ca_phase_o  output  1  high while command/address is transferred.
REQ-015 SHALL have port data_phase_o  output  1  high while in the data phase.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse on transaction completion or abort.

Function
REQ-017 SHALL implement the states IDLE, CA, LAT, DATA, TAIL and CSHI.
REQ-018 SHALL drive trans_ready_o high only in IDLE, and SHALL capture latency_i and burst_len_i on acceptance.
REQ-019 SHALL enter CA in the cycle after acceptance, with cs_no=0 and ca_phase_o=1, and SHALL remain in CA for exactly 3 cycles.
REQ-020 SHALL sample dbl_lat_i in the last CA cycle.
REQ-021 SHALL stay in LAT for L cycles, where L = latency_i, or 2*latency_i if dbl_lat_i is sampled high; if L=0, LAT SHALL be skipped.
REQ-022 SHALL remain in DATA until burst_len_i cycles with ck_en_o=1 have elapsed; if burst_len_i=0, DATA SHALL be skipped.
REQ-023 SHALL form ck_en_o as the registered clock-phase flag (CA, LAT or DATA) AND NOT (hold_i AND state==DATA).
REQ-024 SHALL ignore hold_i outside DATA, and SHALL NOT advance the DATA counter while hold_i is high.
REQ-025 SHALL last TAIL exactly 1 cycle, with ck_en_o=0 and cs_no=0.
REQ-026 SHALL drive cs_no=1 for CsHighCycles cycles in CSHI, then return to IDLE.
REQ-027 SHALL pulse done_o on the first CSHI cycle.
REQ-028 SHALL, on abort_i in CA, LAT or DATA, go to TAIL in the next cycle.
REQ-029 SHALL ignore abort_i in IDLE, TAIL and CSHI.
REQ-030 SHALL give abort_i priority over hold_i and over normal phase advance when both occur in the same cycle.
REQ-031 SHALL use a DATA counter of LenWidth bits and a LAT counter of 5 bits, with no wrap-around (maximum L is 30).

Reset
REQ-032 SHALL, while rst_i is high, force state=IDLE, ck_en_o=0, cs_no=1, ca_phase_o=0, data_phase_o=0, done_o=0, trans_ready_o=1, and clear all counters.
REQ-033 SHALL, on reset mid-transaction, drop ck_en_o and raise cs_no immediately (asynchronously); no done_o pulse SHALL be produced.

Configuration
REQ-034 SHALL, with HYPERBUS_CK_EN_GEN_FIXED_LAT_EN defined, always use L = 2*latency_i and ignore dbl_lat_i.
REQ-035 SHALL, with HYPERBUS_CK_EN_GEN_FIXED_LAT_EN undefined, use the variable latency behaviour of REQ-021.

Verification
REQ-036 Accept latency_i=6, burst_len_i=4, dbl_lat_i=0 -> ck_en_o high for 3+6+4=13 cycles, then TAIL 1 cycle, cs_no high 2 cycles, done_o pulse, trans_ready_o=1.
REQ-037 Same request with dbl_lat_i=1 in the last CA cycle -> LAT lasts 12 cycles and ck_en_o is high for 19 cycles; with the macro defined, 12 cycles regardless of dbl_lat_i.
REQ-038 burst_len_i=8 with hold_i high for cycles 3-5 of DATA -> ck_en_o low for those 3 cycles, DATA lasts 11 cycles, and 8 enabled DATA cycles are observed.
REQ-039 abort_i together with hold_i in the 2nd DATA cycle -> TAIL in the next cycle, then CSHI 2 cycles and done_o; back-to-back valid accepted only after CSHI.
REQ-040 latency_i=0, burst_len_i=0 -> CA 3 cycles then TAIL directly; rst_i asserted in LAT -> ck_en_o=0 and cs_no=1 without a clock edge, and no done_o.
